// File: rtl/j1_stack_pkg.sv
// j1_stack_pkg: shared sizing defaults and pointer-delta encodings
// for the j1 data and return stacks.
package j1_stack_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 5;

    localparam logic [1:0] DELTA_HOLD = 2'b00;
    localparam logic [1:0] DELTA_PUSH = 2'b01;
    localparam logic [1:0] DELTA_POP1 = 2'b11;
    localparam logic [1:0] DELTA_POP2 = 2'b10;

endpackage

// File: rtl/j1_stack_if.sv
// j1_stack_if: stack port bundle; master = core side, slave = stack.
// Carries delta/write/clear requests and top-of-stack/status returns.
interface j1_stack_if
    import j1_stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    logic [1:0]       delta;
    logic             write_enable;
    logic [WIDTH-1:0] write_data;
    logic             clear_flags;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] read_data_second;
    logic [DEPTH-1:0] stack_pointer;
    logic [DEPTH:0]   count;
    logic [DEPTH:0]   high_water;
    logic             overflow;
    logic             underflow;

    modport master (
        output delta, write_enable, write_data, clear_flags,
        input  read_data, read_data_second, stack_pointer,
        input  count, high_water, overflow, underflow
    );

    modport slave (
        input  delta, write_enable, write_data, clear_flags,
        output read_data, read_data_second, stack_pointer,
        output count, high_water, overflow, underflow
    );
endinterface

// File: rtl/j1_stack_ram.sv
// j1_stack_ram: 2**DEPTH x WIDTH register file, one sync write port,
// two async read ports (i_we/i_waddr/i_wdata, i_raddr_a/b -> o_rdata_a/b).
module j1_stack_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 5
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [DEPTH-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [DEPTH-1:0] i_raddr_a,
    input  logic [DEPTH-1:0] i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_a,
    output logic [WIDTH-1:0] o_rdata_b
);
    logic [WIDTH-1:0] r_mem [2**DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/j1_stack.sv
// j1_stack: parametrised j1 stack with occupancy, high-water mark and
// sticky overflow/underflow; ports: clock, active_low_reset, bus (slave).
module j1_stack
    import j1_stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter bit WRAP  = 1'b1
) (
    input  logic        clock,
    input  logic        active_low_reset,
    j1_stack_if.slave   bus
);
    localparam int unsigned FULL_I = 2**DEPTH;
    localparam logic [DEPTH:0] FULL = FULL_I[DEPTH:0];

    logic [DEPTH-1:0]        r_sp;
    logic [DEPTH:0]          r_count;
    logic [DEPTH:0]          r_high;
    logic                    r_over;
    logic                    r_under;

    logic signed [DEPTH+1:0] w_dext;
    logic signed [DEPTH+1:0] w_cnt_next;
    logic [DEPTH-1:0]        w_sp_next;
    logic [DEPTH-1:0]        w_sp_below;
    logic                    w_over;
    logic                    w_under;
    logic                    w_legal;
    logic                    w_move;
    logic [DEPTH:0]          w_cnt_new;
    logic                    w_we;

    always_comb begin
        w_dext = '0;
        unique case (bus.delta)
            DELTA_HOLD: w_dext = '0;
            DELTA_PUSH: w_dext = (DEPTH+2)'(1);
            DELTA_POP1: w_dext = -(DEPTH+2)'(1);
            DELTA_POP2: w_dext = -(DEPTH+2)'(2);
        endcase
    end

    // Count is tracked in DEPTH+2 signed bits so -2 and FULL+1 both fit.
    assign w_cnt_next = $signed({1'b0, r_count}) + w_dext;
    assign w_sp_next  = r_sp + w_dext[DEPTH-1:0];
    assign w_sp_below = r_sp - DEPTH'(1);
    assign w_over     = w_cnt_next > $signed({1'b0, FULL});
    assign w_under    = w_cnt_next[DEPTH+1];
    assign w_legal    = !w_over && !w_under;
    assign w_move     = w_legal || WRAP;

    always_comb begin
        w_cnt_new = r_count;
        if (w_legal) begin
            w_cnt_new = w_cnt_next[DEPTH:0];
        end else if (WRAP) begin
            w_cnt_new = w_over ? FULL : '0;
        end
    end

    // Reset gates the write so an aborted push leaves memory intact.
    assign w_we = bus.write_enable && w_move && active_low_reset;

    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            r_sp    <= '0;
            r_count <= '0;
            r_high  <= '0;
            r_over  <= 1'b0;
            r_under <= 1'b0;
        end else begin
            if (w_move) begin
                r_sp <= w_sp_next;
            end
            r_count <= w_cnt_new;
            if (bus.clear_flags || (w_cnt_new > r_high)) begin
                r_high <= w_cnt_new;
            end
            // A fresh error outranks a same-cycle clear.
            r_over  <= (r_over  && !bus.clear_flags) || w_over;
            r_under <= (r_under && !bus.clear_flags) || w_under;
        end
    end

    j1_stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk     (clock),
        .i_we      (w_we),
        .i_waddr   (w_sp_next),
        .i_wdata   (bus.write_data),
        .i_raddr_a (r_sp),
        .i_raddr_b (w_sp_below),
        .o_rdata_a (bus.read_data),
        .o_rdata_b (bus.read_data_second)
    );

    assign bus.stack_pointer = r_sp;
    assign bus.count         = r_count;
    assign bus.high_water    = r_high;
    assign bus.overflow      = r_over;
    assign bus.underflow     = r_under;
endmodule

// File: tb/tb_j1_stack.sv
// tb_j1_stack: four j1_stack variants driven in lockstep and compared
// against an array/arithmetic reference model.
module tb_j1_stack;
    import j1_stack_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  t_delta = DELTA_HOLD;
    logic        t_we = 1'b0;
    logic [15:0] t_wd = '0;
    logic        t_clr = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    j1_stack_if #(.WIDTH(16), .DEPTH(5)) if0 ();
    j1_stack_if #(.WIDTH(16), .DEPTH(2)) if1 ();
    j1_stack_if #(.WIDTH(16), .DEPTH(2)) if2 ();
    j1_stack_if #(.WIDTH(16), .DEPTH(5)) if3 ();

    assign if0.delta = t_delta;
    assign if1.delta = t_delta;
    assign if2.delta = t_delta;
    assign if3.delta = t_delta;
    assign if0.write_enable = t_we;
    assign if1.write_enable = t_we;
    assign if2.write_enable = t_we;
    assign if3.write_enable = t_we;
    assign if0.write_data = t_wd;
    assign if1.write_data = t_wd;
    assign if2.write_data = t_wd;
    assign if3.write_data = t_wd;
    assign if0.clear_flags = t_clr;
    assign if1.clear_flags = t_clr;
    assign if2.clear_flags = t_clr;
    assign if3.clear_flags = t_clr;

    j1_stack #(.WIDTH(16), .DEPTH(5), .WRAP(1'b0)) u0 (
        .clock(clk), .active_low_reset(rst_n), .bus(if0));
    j1_stack #(.WIDTH(16), .DEPTH(2), .WRAP(1'b1)) u1 (
        .clock(clk), .active_low_reset(rst_n), .bus(if1));
    j1_stack #(.WIDTH(16), .DEPTH(2), .WRAP(1'b0)) u2 (
        .clock(clk), .active_low_reset(rst_n), .bus(if2));
    j1_stack #(.WIDTH(16), .DEPTH(5), .WRAP(1'b1)) u3 (
        .clock(clk), .active_low_reset(rst_n), .bus(if3));

    wire [15:0] o_rd  [4];
    wire [15:0] o_rd2 [4];
    wire [31:0] o_sp  [4];
    wire [31:0] o_cnt [4];
    wire [31:0] o_hw  [4];
    wire        o_ov  [4];
    wire        o_un  [4];

    assign o_rd[0] = if0.read_data;
    assign o_rd[1] = if1.read_data;
    assign o_rd[2] = if2.read_data;
    assign o_rd[3] = if3.read_data;
    assign o_rd2[0] = if0.read_data_second;
    assign o_rd2[1] = if1.read_data_second;
    assign o_rd2[2] = if2.read_data_second;
    assign o_rd2[3] = if3.read_data_second;
    assign o_sp[0] = 32'(if0.stack_pointer);
    assign o_sp[1] = 32'(if1.stack_pointer);
    assign o_sp[2] = 32'(if2.stack_pointer);
    assign o_sp[3] = 32'(if3.stack_pointer);
    assign o_cnt[0] = 32'(if0.count);
    assign o_cnt[1] = 32'(if1.count);
    assign o_cnt[2] = 32'(if2.count);
    assign o_cnt[3] = 32'(if3.count);
    assign o_hw[0] = 32'(if0.high_water);
    assign o_hw[1] = 32'(if1.high_water);
    assign o_hw[2] = 32'(if2.high_water);
    assign o_hw[3] = 32'(if3.high_water);
    assign o_ov[0] = if0.overflow;
    assign o_ov[1] = if1.overflow;
    assign o_ov[2] = if2.overflow;
    assign o_ov[3] = if3.overflow;
    assign o_un[0] = if0.underflow;
    assign o_un[1] = if1.underflow;
    assign o_un[2] = if2.underflow;
    assign o_un[3] = if3.underflow;

    // reference model: one slot per instance
    int          m_n   [4] = '{32, 4, 4, 32};
    bit          m_wrap[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int          m_sp  [4];
    int          m_cnt [4];
    int          m_hw  [4];
    bit          m_ov  [4];
    bit          m_un  [4];
    logic [15:0] m_mem [4][32];
    bit          m_val [4][32];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int dval(input logic [1:0] d);
        case (d)
            2'b01:   return 1;
            2'b11:   return -1;
            2'b10:   return -2;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_sp[k] = 0;
            m_cnt[k] = 0;
            m_hw[k] = 0;
            m_ov[k] = 1'b0;
            m_un[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        int n, cn, nn;
        bit e_ov, e_un, mv;
        n = dval(t_delta);
        for (int k = 0; k < 4; k++) begin
            nn = m_n[k];
            cn = m_cnt[k] + n;
            e_ov = cn > nn;
            e_un = cn < 0;
            mv = !(e_ov || e_un) || m_wrap[k];
            if (mv) begin
                m_sp[k] = ((m_sp[k] + n) % nn + nn) % nn;
                m_cnt[k] = e_ov ? nn : (e_un ? 0 : cn);
                if (t_we) begin
                    m_mem[k][m_sp[k]] = t_wd;
                    m_val[k][m_sp[k]] = 1'b1;
                end
            end
            if (t_clr) begin
                m_ov[k] = 1'b0;
                m_un[k] = 1'b0;
                m_hw[k] = m_cnt[k];
            end else if (m_cnt[k] > m_hw[k]) begin
                m_hw[k] = m_cnt[k];
            end
            if (e_ov) m_ov[k] = 1'b1;
            if (e_un) m_un[k] = 1'b1;
        end
    endtask

    task automatic check_all();
        int b;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("u%0d.sp", k), o_sp[k], m_sp[k]);
            check($sformatf("u%0d.count", k), o_cnt[k], m_cnt[k]);
            check($sformatf("u%0d.high_water", k), o_hw[k], m_hw[k]);
            check($sformatf("u%0d.overflow", k), 32'(o_ov[k]), 32'(m_ov[k]));
            check($sformatf("u%0d.underflow", k), 32'(o_un[k]), 32'(m_un[k]));
            if (m_val[k][m_sp[k]])
                check($sformatf("u%0d.read_data", k), 32'(o_rd[k]),
                      32'(m_mem[k][m_sp[k]]));
            b = (m_sp[k] + m_n[k] - 1) % m_n[k];
            if (m_val[k][b])
                check($sformatf("u%0d.read_data_second", k), 32'(o_rd2[k]),
                      32'(m_mem[k][b]));
        end
    endtask

    task automatic step(input logic [1:0] d, input logic we,
                        input logic [15:0] wd, input logic clr);
        t_delta = d;
        t_we = we;
        t_wd = wd;
        t_clr = clr;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_phase(input int cycles, input int push_pct);
        int r;
        logic [1:0] d;
        for (int i = 0; i < cycles; i++) begin
            r = int'($urandom_range(99));
            if (r < push_pct) d = DELTA_PUSH;
            else if (r < push_pct + 15) d = DELTA_HOLD;
            else if (r < push_pct + 15 + (85 - push_pct) / 2) d = DELTA_POP1;
            else d = DELTA_POP2;
            step(d, ($urandom_range(99) < 70), 16'($urandom),
                 ($urandom_range(99) < 5));
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 32; j++)
                m_val[k][j] = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        step(DELTA_PUSH, 1'b1, 16'h1111, 1'b0);
        step(DELTA_PUSH, 1'b1, 16'h2222, 1'b0);
        step(DELTA_PUSH, 1'b1, 16'h3333, 1'b0);
        check("plan.push.rd", 32'(o_rd[0]), 32'h3333);
        check("plan.push.rd2", 32'(o_rd2[0]), 32'h2222);
        check("plan.push.sp", o_sp[0], 32'd3);
        check("plan.push.hw", o_hw[0], 32'd3);

        step(DELTA_POP2, 1'b0, 16'h0, 1'b0);
        check("plan.pop2.rd", 32'(o_rd[0]), 32'h1111);
        check("plan.pop2.cnt", o_cnt[0], 32'd1);

        step(DELTA_POP2, 1'b1, 16'hBEEF, 1'b0);
        check("plan.uf.flag", 32'(o_un[0]), 32'd1);
        check("plan.uf.rd", 32'(o_rd[0]), 32'h1111);
        check("plan.uf.wrap.sp", o_sp[3], 32'd31);
        step(DELTA_HOLD, 1'b0, 16'h0, 1'b1);
        check("plan.clr.un", 32'(o_un[0]), 32'd0);
        check("plan.clr.hw", o_hw[0], 32'd1);

        do_reset();
        for (int i = 0; i < 5; i++)
            step(DELTA_PUSH, 1'b1, 16'(16'hA0 + i), 1'b0);
        check("plan.ofw.sp", o_sp[1], 32'd1);
        check("plan.ofw.rd", 32'(o_rd[1]), 32'hA4);
        check("plan.ofw.hw", o_hw[1], 32'd4);
        check("plan.ofg.sp", o_sp[2], 32'd0);
        check("plan.ofg.rd", 32'(o_rd[2]), 32'hA3);
        check("plan.ofg.ov", 32'(o_ov[2]), 32'd1);

        step(DELTA_HOLD, 1'b0, 16'h0, 1'b1);
        check("plan.clr.ov", 32'(o_ov[1]), 32'd0);
        step(DELTA_PUSH, 1'b1, 16'h55, 1'b1);
        check("plan.errclr.ov1", 32'(o_ov[1]), 32'd1);
        check("plan.errclr.ov2", 32'(o_ov[2]), 32'd1);
        step(DELTA_POP2, 1'b0, 16'h0, 1'b0);
        check("plan.ofg.keepA0", 32'(o_rd2[2]), 32'hA0);

        // async reset between edges while a push+write is presented
        t_delta = DELTA_PUSH;
        t_we = 1'b1;
        t_wd = 16'hDEAD;
        t_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(DELTA_PUSH, 1'b0, 16'h0, 1'b0);
        check("plan.rst.nowrite", 32'(o_rd[0] == 16'hDEAD), 32'd0);

        rand_phase(300, 55);
        rand_phase(300, 25);
        do_reset();
        rand_phase(300, 40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/j1_stack.md
Name: j1_stack

Overview:
- Parametrised hardware stack for the j1 core. One instance serves as the data stack and one as the return stack.
- Replaces the fixed-size stack with these additions:
  - configurable width and depth;
  - signed pointer deltas of +1/0/−1/−2;
  - occupancy count, high-water mark, and sticky overflow/underflow flags;
  - selectable wrap or guard mode on overflow/underflow.
- Sits between the core's decode/ALU logic and its stack-pointer handling.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 5, pointer width in bits; the stack holds 2**DEPTH entries.
- WRAP, 1, overflow/underflow mode:
  - 1 = circular pointer (classic j1);
  - 0 = guard mode, in which the illegal move is suppressed.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- active_low_reset  input  1  asynchronous, active-low reset.
- delta  input  2  pointer move, two's complement: 00 hold, 01 push +1, 11 pop −1, 10 pop −2.
- write_enable  input  1  write write_data at the post-move pointer this cycle.
- write_data  input  WIDTH  data to store.
- read_data  output  WIDTH  mem[sp]; combinational read of the current top entry.
- read_data_second  output  WIDTH  mem[sp−1 mod 2**DEPTH]; entry below the top.
- stack_pointer  output  DEPTH  current pointer sp.
- count  output  DEPTH+1  occupancy, 0..2**DEPTH.
- high_water  output  DEPTH+1  maximum count seen since reset or since clear_flags.
- overflow  output  1  sticky; set on a push while count == 2**DEPTH.
- underflow  output  1  sticky; set on a pop of n when count < n.
- clear_flags  input  1  clears overflow, underflow and high_water.

Behaviour:
- Reset (asynchronous, active_low_reset = 0):
  - sp = 0, count = 0, high_water = 0, overflow = 0, underflow = 0.
  - Memory array is not reset; read_data is undefined until the entry is written.
- Move calculation:
  - sp_next = sp + sign_extend(delta), modulo 2**DEPTH.
  - count_next = count + sign_extend(delta), computed in DEPTH+2 signed bits.
- Write rule: if write_enable, then mem[sp_next] <= write_data on the same edge as the pointer update.
  - Push-and-write therefore stores to the new top.
  - Hold-and-write replaces the top.
- Read latency: read_data and read_data_second are zero-latency combinational reads of the current sp. The new top is visible in the cycle after the edge.
- Legal move (0 ≤ count_next ≤ 2**DEPTH): sp <= sp_next, count <= count_next.
- Illegal move, WRAP = 1:
  - sp <= sp_next (wraps).
  - count saturates: 2**DEPTH on overflow, 0 on underflow.
  - The write is performed.
  - overflow or underflow <= 1.
- Illegal move, WRAP = 0:
  - sp, count and memory are unchanged, and the write is suppressed.
  - overflow or underflow <= 1.
- high_water: updated to count's new value whenever that value exceeds high_water.
- clear_flags:
  - clears overflow, underflow and high_water; high_water is reloaded with the post-move count.
  - If an error occurs in the same cycle, the flag set wins.
- Boundaries:
  - pop −2 with count == 1 is an underflow.
  - Push at count == 2**DEPTH − 1 is legal and reaches full.
  - delta = 00 with write_enable at count == 0 is legal: it writes mem[sp] and count stays 0. This is j1 "replace T" semantics; count tracks pushes only.
- Reset asserted mid-operation aborts any write in progress; the state returns to reset values immediately.

Decomposition:
- Shared package holds:
  - WIDTH and DEPTH defaults, reused from common.h;
  - delta encoding constants: DELTA_HOLD, DELTA_PUSH, DELTA_POP1, DELTA_POP2.
- Sub-module j1_stack_ram: 2**DEPTH × WIDTH register file with one synchronous write port and two asynchronous read ports.
- All pointer, count and flag logic stays in j1_stack.

Test Plan:
- Push sequence: reset; push 0x1111, 0x2222, 0x3333 (delta = 01, write_enable = 1).
  - Required: read_data = 0x3333, read_data_second = 0x2222, sp = 3, count = 3, high_water = 3.
- Pop-2: from that state, pop −2 (delta = 10).
  - Required: read_data = 0x1111, sp = 1, count = 1, no flags.
- Underflow, WRAP = 0: at count = 1, apply pop −2.
  - Required: underflow = 1; sp, count and read_data unchanged.
  - Then clear_flags pulse → underflow = 0, high_water = 1.
- Overflow, WRAP = 1, DEPTH = 2: push 5 values 0xA0..0xA4.
  - Required: after the 5th push, overflow = 1, count = 4, sp = 1 (wrapped), read_data = 0xA4, high_water = 4.
- Overflow, WRAP = 0, DEPTH = 2: push 5 values.
  - Required: after the 5th push, overflow = 1, sp = 0, count = 4, read_data = 0xA3; entry 0xA0 is not overwritten.
- Asynchronous reset mid-push: assert active_low_reset low between edges while delta = 01.
  - Required: sp = 0, count = 0 and flags = 0 immediately, with no write on the next edge while reset is held.
- Simultaneous error and clear: push with count = 2**DEPTH and clear_flags = 1 in the same cycle.
  - Required: overflow = 1 after the edge.
